// File: rtl/fft_frame_sequencer.sv
// ============================================================================
// fft_frame_sequencer: serial sample collector and bin emitter around an
// 8-point FFT pipeline. Optional macro FFT_SCALE_EN divides output bins by 8.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fft_frame_sequencer #(
  parameter int N   = 4,
  parameter int LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [2**N-1:0]   i_in_data,
  output logic [2**N-1:0]   o_fft_a0,
  output logic [2**N-1:0]   o_fft_a1,
  output logic [2**N-1:0]   o_fft_a2,
  output logic [2**N-1:0]   o_fft_a3,
  output logic [2**N-1:0]   o_fft_a4,
  output logic [2**N-1:0]   o_fft_a5,
  output logic [2**N-1:0]   o_fft_a6,
  output logic [2**N-1:0]   o_fft_a7,
  input  logic [2**N-1:0]   i_fft_y0,
  input  logic [2**N-1:0]   i_fft_y4,
  input  logic [2**N-1:0]   i_fft_yr1,
  input  logic [2**N-1:0]   i_fft_yi1,
  input  logic [2**N-1:0]   i_fft_yr2,
  input  logic [2**N-1:0]   i_fft_yi2,
  input  logic [2**N-1:0]   i_fft_yr3,
  input  logic [2**N-1:0]   i_fft_yi3,
  input  logic [2**N-1:0]   i_fft_yr5,
  input  logic [2**N-1:0]   i_fft_yi5,
  input  logic [2**N-1:0]   i_fft_yr6,
  input  logic [2**N-1:0]   i_fft_yi6,
  input  logic [2**N-1:0]   i_fft_yr7,
  input  logic [2**N-1:0]   i_fft_yi7,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [2**N-1:0]   o_out_re,
  output logic [2**N-1:0]   o_out_im,
  output logic [2:0]        o_out_idx,
  output logic              o_busy
);

  localparam int W     = 2**N;
  localparam int LAT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam logic [LAT_W-1:0] LAT_CNT = LAT_W'(LAT);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_cnt;
  logic [LAT_W-1:0]   r_wcnt;
  logic [2:0]         r_idx;
  logic [W-1:0]       r_a      [8];
  logic [W-1:0]       r_res_re [8];
  logic [W-1:0]       r_res_im [8];

  logic               w_accept;
  logic               w_capture;
  logic               w_xfer;
  logic [W-1:0]       w_re;
  logic [W-1:0]       w_im;

  assign w_accept  = i_in_valid && (r_state == S_LOAD);
  assign w_capture = (r_state == S_WAIT) && (r_wcnt == LAT_CNT);
  assign w_xfer    = (r_state == S_DRAIN) && i_out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  if (w_accept && (r_cnt == 3'd7)) w_state_nxt = S_WAIT;
      S_WAIT:  if (w_capture)                   w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_xfer && (r_idx == 3'd7))   w_state_nxt = S_LOAD;
      default:                                  w_state_nxt = S_LOAD;
    endcase
  end

  // Counters wrap naturally at 8, so no explicit clear is needed on frame end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_wcnt <= '0;
      r_idx  <= '0;
      for (int i = 0; i < 8; i++) begin
        r_a[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_a[r_cnt] <= i_in_data;
        r_cnt      <= r_cnt + 3'd1;
      end
      if (r_state == S_WAIT) begin
        r_wcnt <= r_wcnt + LAT_W'(1);
      end else begin
        r_wcnt <= '0;
      end
      if (w_capture) begin
        r_idx <= 3'd0;
      end else if (w_xfer) begin
        r_idx <= r_idx + 3'd1;
      end
    end
  end

  // Bins 0 and 4 are purely real; their imaginary slots stay zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_res_re[i] <= '0;
        r_res_im[i] <= '0;
      end
    end else if (w_capture) begin
      r_res_re[0] <= i_fft_y0;   r_res_im[0] <= '0;
      r_res_re[1] <= i_fft_yr1;  r_res_im[1] <= i_fft_yi1;
      r_res_re[2] <= i_fft_yr2;  r_res_im[2] <= i_fft_yi2;
      r_res_re[3] <= i_fft_yr3;  r_res_im[3] <= i_fft_yi3;
      r_res_re[4] <= i_fft_y4;   r_res_im[4] <= '0;
      r_res_re[5] <= i_fft_yr5;  r_res_im[5] <= i_fft_yi5;
      r_res_re[6] <= i_fft_yr6;  r_res_im[6] <= i_fft_yi6;
      r_res_re[7] <= i_fft_yr7;  r_res_im[7] <= i_fft_yi7;
    end
  end

  assign w_re = r_res_re[r_idx];
  assign w_im = r_res_im[r_idx];

`ifdef FFT_SCALE_EN
  assign o_out_re = $signed(w_re) >>> 3;
  assign o_out_im = $signed(w_im) >>> 3;
`else
  assign o_out_re = w_re;
  assign o_out_im = w_im;
`endif

  assign o_in_ready  = (r_state == S_LOAD);
  assign o_busy      = (r_state != S_LOAD);
  assign o_out_valid = (r_state == S_DRAIN);
  assign o_out_idx   = r_idx;

  assign o_fft_a0 = r_a[0];
  assign o_fft_a1 = r_a[1];
  assign o_fft_a2 = r_a[2];
  assign o_fft_a3 = r_a[3];
  assign o_fft_a4 = r_a[4];
  assign o_fft_a5 = r_a[5];
  assign o_fft_a6 = r_a[6];
  assign o_fft_a7 = r_a[7];

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_sequencer.sv
// ============================================================================
// tb_fft_frame_sequencer: scoreboard bench with a behavioural 3-cycle FFT.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fft_frame_sequencer;

  localparam int N   = 4;
  localparam int LAT = 3;
  localparam int W   = 16;

  typedef logic [W-1:0] frame_t [8];
  typedef struct packed {
    logic [2:0]   idx;
    logic [W-1:0] re;
    logic [W-1:0] im;
  } bin_t;

  localparam int COS_T [8] = '{256, 181, 0, -181, -256, -181, 0, 181};
  localparam int SIN_T [8] = '{0, 181, 256, 181, 0, -181, -256, -181};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0] in_data, out_re, out_im;
  logic [2:0]   out_idx;
  frame_t       fa;
  frame_t       s1, s2, s3;
  logic [W-1:0] y_re [8];
  logic [W-1:0] y_im [8];

  fft_frame_sequencer #(.N(N), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_fft_a0(fa[0]), .o_fft_a1(fa[1]), .o_fft_a2(fa[2]), .o_fft_a3(fa[3]),
    .o_fft_a4(fa[4]), .o_fft_a5(fa[5]), .o_fft_a6(fa[6]), .o_fft_a7(fa[7]),
    .i_fft_y0(y_re[0]), .i_fft_y4(y_re[4]),
    .i_fft_yr1(y_re[1]), .i_fft_yi1(y_im[1]),
    .i_fft_yr2(y_re[2]), .i_fft_yi2(y_im[2]),
    .i_fft_yr3(y_re[3]), .i_fft_yi3(y_im[3]),
    .i_fft_yr5(y_re[5]), .i_fft_yi5(y_im[5]),
    .i_fft_yr6(y_re[6]), .i_fft_yi6(y_im[6]),
    .i_fft_yr7(y_re[7]), .i_fft_yi7(y_im[7]),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_re(out_re), .o_out_im(out_im), .o_out_idx(out_idx),
    .o_busy(busy)
  );

  function automatic logic [W-1:0] dft_re(input frame_t x, input int k);
    int acc = 0;
    for (int n = 0; n < 8; n++) acc += int'($signed(x[n])) * COS_T[(n * k) % 8];
    return W'(acc >>> 8);
  endfunction

  function automatic logic [W-1:0] dft_im(input frame_t x, input int k);
    int acc = 0;
    for (int n = 0; n < 8; n++) acc -= int'($signed(x[n])) * SIN_T[(n * k) % 8];
    return W'(acc >>> 8);
  endfunction

  function automatic logic [W-1:0] scl(input logic [W-1:0] v);
`ifdef FFT_SCALE_EN
    return W'($signed(v) >>> 3);
`else
    return v;
`endif
  endfunction

  // Stand-in FFT: three pipeline registers, result valid LAT cycles after a* settle
  always @(posedge clk) begin
    s1 <= fa;
    s2 <= s1;
    s3 <= s2;
  end

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      y_re[k] = dft_re(s3, k);
      y_im[k] = dft_im(s3, k);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  bin_t   sb [$];
  frame_t frm, last_frm;
  int     nacc = 0, cyc = 0, acc_cyc = 0, frames_in = 0;
  logic   prev_valid = 1'b0;

  always @(negedge clk) begin
    bin_t e;
    cyc++;
    if (!rst_n) begin
      sb.delete();
      nacc       = 0;
      prev_valid = 1'b0;
    end else begin
      check_eq("in_ready_vs_busy", {31'd0, in_ready}, {31'd0, ~busy});
      if (in_valid && in_ready) begin
        frm[nacc] = in_data;
        nacc++;
        if (nacc == 8) begin
          for (int k = 0; k < 8; k++) begin
            e.idx = 3'(k);
            e.re  = scl(dft_re(frm, k));
            e.im  = (k == 0 || k == 4) ? '0 : scl(dft_im(frm, k));
            sb.push_back(e);
          end
          last_frm = frm;
          acc_cyc  = cyc;
          nacc     = 0;
          frames_in++;
        end
      end
      if (out_valid && !prev_valid) begin
        check_eq("first_valid_latency", cyc - acc_cyc, 5);
        for (int k = 0; k < 8; k++) check_eq($sformatf("fft_a%0d", k), {16'd0, fa[k]}, {16'd0, last_frm[k]});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_bin", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("bin_idx", {29'd0, out_idx}, {29'd0, e.idx});
          check_eq($sformatf("bin%0d_re", e.idx), {16'd0, out_re}, {16'd0, e.re});
          check_eq($sformatf("bin%0d_im", e.idx), {16'd0, out_im}, {16'd0, e.im});
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic send(input logic [W-1:0] d);
    logic rdy;
    int   t = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      rdy = in_ready;
      @(posedge clk); #1;
      t++;
    end while (!rdy && t < 200);
    if (!rdy) check_eq("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic send_frame(input frame_t f);
    for (int i = 0; i < 8; i++) send(f[i]);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (busy) check_eq("idle_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_bin(input logic [2:0] k);
    int t = 0;
    while (!(out_valid && out_idx == k) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!(out_valid && out_idx == k)) check_eq("wait_bin_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    logic [W-1:0] h_re, h_im;
    frame_t       f;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_busy",      {31'd0, busy},      32'd0);
    check_eq("rst_idx",       {29'd0, out_idx},   32'd0);
    check_eq("rst_re",        {16'd0, out_re},    32'd0);
    check_eq("rst_im",        {16'd0, out_im},    32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    f = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    send_frame(f);
    wait_idle();

    f = '{default: 16'd1};
    send_frame(f);
    wait_idle();

    f = '{16'd3, 16'hFFFE, 16'd5, 16'd7, 16'hFFF8, 16'd1, 16'd0, 16'd4};
    send_frame(f);
    wait_bin(3'd3);
    out_ready = 1'b0;
    h_re = out_re;
    h_im = out_im;
    repeat (10) begin
      @(posedge clk); #1;
      check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
      check_eq("stall_idx",   {29'd0, out_idx},   32'd3);
      check_eq("stall_re",    {16'd0, out_re},    {16'd0, h_re});
      check_eq("stall_im",    {16'd0, out_im},    {16'd0, h_im});
    end
    out_ready = 1'b1;
    wait_idle();

    for (int i = 1; i <= 16; i++) send(W'(i));
    in_valid = 1'b0;
    wait_idle();
    check_eq("frame2_a0", {16'd0, fa[0]}, 32'd9);
    check_eq("frame2_a7", {16'd0, fa[7]}, 32'd16);

    f = '{16'd2, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    send_frame(f);
    wait_bin(3'd2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("midrst_busy",      {31'd0, busy},      32'd0);
    check_eq("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    check_eq("midrst_idx",       {29'd0, out_idx},   32'd0);
    for (int k = 0; k < 8; k++) check_eq($sformatf("midrst_a%0d", k), {16'd0, fa[k]}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    f = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    send_frame(f);
    wait_idle();

    f = '{default: 16'hFFFF};
    send_frame(f);
    wait_idle();

    check_eq("sb_drained", sb.size(), 32'd0);
    check_eq("frames_seen", frames_in, 32'd8);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
